kanagawa_credit_sender: RTL and testbench

Transmit-side companion to the zero-bit FIFO counter. It holds a local credit pool equal to the receiver's queue depth, consumes one credit per transferred event, and replenishes credits as the receiver pops entries and returns them. It sits at the producer end of a credit-flow-controlled link, so the producer never overruns the remote counter or FIFO. All outputs are registered except `send_out`.

---
 rtl/kanagawa_credit_sender.sv | 70 +++++++
 tb/tb_kanagawa_credit_sender.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/kanagawa_credit_sender.sv
// Producer-side credit pool for a credit-flow-controlled link: spends one
// credit per issued event and replenishes from the receiver's returned count.
module kanagawa_credit_sender #(
  parameter int                 LOG_DEPTH         = 1,
  parameter int                 RETURN_WIDTH      = 1,
  parameter logic [LOG_DEPTH:0] LOW_CREDIT_MARGIN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic                    send_out,
  input  logic [RETURN_WIDTH-1:0] credit_return_in,
  output logic [LOG_DEPTH:0]      credits_out,
  output logic                    low_credit_out,
  output logic                    idle_out,
  output logic                    overflow_err_out
);

  localparam int                 CW   = LOG_DEPTH + 1;
  localparam int                 SW   = LOG_DEPTH + RETURN_WIDTH + 1;
  localparam logic [CW-1:0]      FULL = CW'(1) << LOG_DEPTH;
  localparam logic               LOW_AT_RESET = (FULL <= LOW_CREDIT_MARGIN);

  logic [CW-1:0] r_credits;
  logic          r_ready;
  logic          r_low;
  logic          r_idle;
  logic          r_err;

  logic          w_send;
  logic [SW-1:0] w_sum;
  logic          w_overflow;
  logic [CW-1:0] w_credits_nxt;

  // Sending needs r_ready, so credits >= 1 and the subtraction cannot wrap.
  assign w_send = valid_in & r_ready & ~rst;

  always_comb begin
    w_sum         = SW'(r_credits) + SW'(credit_return_in) - SW'(w_send);
    w_overflow    = (w_sum > SW'(FULL));
    w_credits_nxt = w_overflow ? FULL : w_sum[CW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= FULL;
      r_ready   <= 1'b1;
      r_low     <= LOW_AT_RESET;
      r_idle    <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_credits <= w_credits_nxt;
      r_ready   <= (w_credits_nxt != '0);
      r_low     <= (w_credits_nxt <= LOW_CREDIT_MARGIN);
      r_idle    <= (w_credits_nxt == FULL);
      r_err     <= r_err | w_overflow;
    end
  end

  assign send_out         = w_send;
  assign ready_out        = r_ready;
  assign credits_out      = r_credits;
  assign low_credit_out   = r_low;
  assign idle_out         = r_idle;
  assign overflow_err_out = r_err;

endmodule

// File: tb/tb_kanagawa_credit_sender.sv
// Scoreboard bench for kanagawa_credit_sender (LOG_DEPTH=2, RETURN_WIDTH=2,
// margin 1): a reference pool model queues expected post-edge state.
module tb_kanagawa_credit_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [1:0] credit_return_in = 2'd0;
  logic       ready_out;
  logic       send_out;
  logic [2:0] credits_out;
  logic       low_credit_out;
  logic       idle_out;
  logic       overflow_err_out;

  kanagawa_credit_sender #(
    .LOG_DEPTH        (2),
    .RETURN_WIDTH     (2),
    .LOW_CREDIT_MARGIN(3'd1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .send_out         (send_out),
    .credit_return_in (credit_return_in),
    .credits_out      (credits_out),
    .low_credit_out   (low_credit_out),
    .idle_out         (idle_out),
    .overflow_err_out (overflow_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int credits;
    bit ready;
    bit low;
    bit idle;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_credits = 4;
  bit   m_err     = 1'b0;
  int   n_sends;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle, check the combinational send, then the registered state.
  task automatic step(input bit v, input int ret, input bit r);
    bit   exp_send;
    int   sum;
    exp_t e;
    valid_in         = v;
    credit_return_in = 2'(ret);
    rst              = r;
    #1;
    exp_send = !r && v && (m_credits != 0);
    check("send_out", int'(send_out), int'(exp_send));
    if (send_out) n_sends++;
    if (r) begin
      m_credits = 4;
      m_err     = 1'b0;
    end else begin
      sum = m_credits + ret - int'(exp_send);
      if (sum > 4) begin
        m_credits = 4;
        m_err     = 1'b1;
      end else begin
        m_credits = sum;
      end
    end
    e.credits = m_credits;
    e.ready   = (m_credits != 0);
    e.low     = (m_credits <= 1);
    e.idle    = (m_credits == 4);
    e.err     = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("credits_out",      int'(credits_out),      e.credits);
    check("ready_out",        int'(ready_out),        int'(e.ready));
    check("low_credit_out",   int'(low_credit_out),   int'(e.low));
    check("idle_out",         int'(idle_out),         int'(e.idle));
    check("overflow_err_out", int'(overflow_err_out), int'(e.err));
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(1'b0, 0, 1'b1);
    check("rst_credits", int'(credits_out), 4);
    check("rst_low",     int'(low_credit_out), 0);

    // Exhaustion: six requests, only four may issue.
    n_sends = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 0, 1'b0);
    check("exhaust_sends",   n_sends, 4);
    check("exhaust_credits", int'(credits_out), 0);
    check("exhaust_ready",   int'(ready_out), 0);

    // Simultaneous send and return at credits=2.
    step(1'b0, 2, 1'b0);
    step(1'b1, 1, 1'b0);
    check("simul_credits", int'(credits_out), 2);

    // At credits=0 the return lands, the send does not.
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    n_sends = 0;
    step(1'b1, 1, 1'b0);
    check("zero_nosend",  n_sends, 0);
    check("zero_credits", int'(credits_out), 1);

    // Multi-credit return from empty.
    step(1'b1, 0, 1'b0);
    step(1'b0, 3, 1'b0);
    check("multi_credits", int'(credits_out), 3);

    // Overflow from full, then sticky through normal traffic.
    step(1'b0, 1, 1'b0);
    step(1'b0, 1, 1'b0);
    check("ovf_credits", int'(credits_out), 4);
    step(1'b1, 0, 1'b0);
    step(1'b0, 1, 1'b0);
    step(1'b1, 1, 1'b0);
    check("ovf_sticky", int'(overflow_err_out), 1);

    // Reset mid-operation at credits=1 with valid_in held.
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
    check("pre_rst_credits", int'(credits_out), 1);
    step(1'b1, 0, 1'b1);
    check("mid_rst_credits", int'(credits_out), 4);
    check("mid_rst_err",     int'(overflow_err_out), 0);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)) & ((i % 3 == 0) ? 3 : 1), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
